sample_recorder: RTL and testbench



---
 rtl/sample_recorder_pkg.sv | 7 +
 rtl/sample_recorder_trigger_detect.sv | 15 +
 rtl/sample_recorder.sv | 67 ++++++
 tb/tb_sample_recorder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sample_recorder_pkg.sv
// recorder_pkg: state encoding and default geometry shared by sample_recorder and its submodule
package recorder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RECORD = 2'd2, DONE = 2'd3} state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] MAXCOUNT_DEF = 16'd43840;
endpackage

// File: rtl/sample_recorder_trigger_detect.sv
// trigger_detect: flags a signed sample whose saturated magnitude reaches THRESHOLD (sample_in -> hit)
module trigger_detect #(
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] THRESHOLD = DATA_W'(2048)
) (
  input  logic [DATA_W-1:0] sample_in,
  output logic              hit
);
  logic [DATA_W-1:0] mag;
  always_comb begin
    mag = !sample_in[DATA_W-1] ? sample_in :
          sample_in == {1'b1, {(DATA_W-1){1'b0}}} ? {1'b0, {(DATA_W-1){1'b1}}} : -sample_in;
    hit = mag >= THRESHOLD;
  end
endmodule

// File: rtl/sample_recorder.sv
// sample_recorder: strobed samples -> RAM writes at 0..MAXCOUNT (mem_addr/mem_data/mem_we), reports rec_len/busy/full; SAMPLE_RECORDER_TRIGGER_EN adds magnitude-triggered start
module sample_recorder
  import recorder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] MAXCOUNT = ADDR_W'(MAXCOUNT_DEF)
`ifdef SAMPLE_RECORDER_TRIGGER_EN
  , parameter logic [DATA_W-1:0] THRESHOLD = DATA_W'(2048)
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic              stop,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] rec_len,
  output logic              busy,
  output logic              full
);
  state_t state, state_n;
  logic [ADDR_W-1:0] wr_cnt;
  logic hit, wr;
`ifdef SAMPLE_RECORDER_TRIGGER_EN
  localparam state_t START = ARMED;
  trigger_detect #(.DATA_W(DATA_W), .THRESHOLD(THRESHOLD)) u_trig (.sample_in(sample_in), .hit(hit));
`else
  localparam state_t START = RECORD;
  assign hit = 1'b0;
`endif
  always_comb begin
    wr = sample_valid & ~arm & ~stop & (state == RECORD | (state == ARMED & hit));
    state_n = arm ? START :
              (stop & (state == RECORD | state == ARMED)) | (wr & wr_cnt == MAXCOUNT) ? DONE :
              wr ? RECORD : state;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      wr_cnt <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we <= 1'b0;
      rec_len <= '0;
      busy <= 1'b0;
      full <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n == ARMED || state_n == RECORD;
      mem_we <= wr;
      if (arm) begin
        wr_cnt <= '0;
        rec_len <= '0;
        full <= 1'b0;
      end else if (wr) begin
        mem_addr <= wr_cnt;
        mem_data <= sample_in;
        wr_cnt <= wr_cnt + 1'b1;
        rec_len <= wr_cnt + 1'b1;
        full <= wr_cnt == MAXCOUNT;
      end
    end
endmodule

// File: tb/tb_sample_recorder.sv
// tb_sample_recorder: randomized scoreboard bench for sample_recorder against a queue-based capture model
module tb_sample_recorder;
  localparam int MC = 7;
  localparam int TH = 2048;
`ifdef SAMPLE_RECORDER_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0, arm = 1'b0, stop = 1'b0, sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic [15:0] mem_addr, mem_data, rec_len;
  logic mem_we, busy, full;
  int checks = 0, passed = 0, cyc = 0;
  typedef struct {int addr; int data; int at;} wr_t;
  wr_t expq[$];
  int rec[$];
  int mode = 0;
  bit mfull = 1'b0;

  sample_recorder #(.MAXCOUNT(16'(MC))) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .stop(stop), .sample_valid(sample_valid),
    .sample_in(sample_in), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .rec_len(rec_len), .busy(busy), .full(full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string n, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (resetn && mem_we) begin
      checks++;
      if (expq.size() == 0)
        $display("FAIL write: got addr %0d data %0d at cycle %0d expected no write", mem_addr, mem_data, cyc);
      else begin
        e = expq.pop_front();
        if (int'(mem_addr) == e.addr && int'(mem_data) == e.data && cyc == e.at) passed++;
        else $display("FAIL write: got addr %0d data %0d cycle %0d expected addr %0d data %0d cycle %0d",
                      mem_addr, mem_data, cyc, e.addr, e.data, e.at);
      end
    end else if (expq.size() > 0 && expq[0].at <= cyc) begin
      e = expq.pop_front();
      checks++;
      $display("FAIL write: got none at cycle %0d expected addr %0d data %0d", cyc, e.addr, e.data);
    end
  end

  task automatic step(bit a, bit s, bit v, logic [15:0] x);
    int sv, m;
    @(negedge clk);
    arm = a; stop = s; sample_valid = v; sample_in = x;
    sv = int'($signed(x));
    m = sv < 0 ? -sv : sv;
    if (m > 32767) m = 32767;
    if (a) begin
      rec.delete();
      mfull = 1'b0;
      mode = TRIG ? 1 : 2;
    end else if (s && (mode == 1 || mode == 2)) mode = 3;
    else if (v && (mode == 2 || (mode == 1 && m >= TH))) begin
      expq.push_back('{rec.size(), int'(x), cyc + 1});
      rec.push_back(int'(x));
      mode = 2;
      if (rec.size() == MC + 1) begin
        mode = 3;
        mfull = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("rec_len", int'(rec_len), rec.size());
    check("full", int'(full), int'(mfull));
    check("busy", int'(busy), int'(mode == 1 || mode == 2));
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_data", int'(mem_data), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_rec_len", int'(rec_len), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_full", int'(full), 0);
  endtask

  task automatic reset_mid();
    #1 resetn = 1'b0;
    arm = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    #1 check_reset_outputs();
    rec.delete();
    expq.delete();
    mode = 0;
    mfull = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [15:0] x;
    int r;
    #3 check_reset_outputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    step(1, 0, 1, 16'd42);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 16'(i));
      step(0, 0, 0, 16'd0);
    end
    step(0, 1, 0, 16'd0);
    step(0, 1, 0, 16'd0);
    step(1, 0, 0, 16'd0);
    step(0, 0, 1, 16'd77);
    step(0, 0, 1, 16'd78);
    step(0, 1, 1, 16'd99);
    step(0, 0, 1, 16'd5);
    step(1, 0, 0, 16'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'(200 + i));
    step(1, 1, 1, 16'd55);
    step(0, 0, 1, 16'd66);
    step(1, 0, 0, 16'd0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 16'(100 + i));
    step(1, 0, 0, 16'd0);
    step(0, 0, 1, 16'd9);
    step(0, 1, 0, 16'd0);
    step(1, 0, 0, 16'd0);
    step(0, 0, 1, 16'd100);
    step(0, 0, 1, 16'(-100));
    step(0, 0, 1, 16'(-3000));
    step(0, 0, 1, 16'd7);
    step(0, 1, 0, 16'd0);
    step(1, 0, 0, 16'd0);
    step(0, 0, 1, 16'h8000);
    step(0, 0, 1, 16'd3);
    step(0, 1, 0, 16'd0);
    step(1, 0, 0, 16'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 16'(-2500 - i));
    reset_mid();
    step(0, 0, 1, 16'd1);
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      x = $urandom_range(0, 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 8000)) - 4000);
      step(r < 4, r >= 4 && r < 7, 1'($urandom_range(0, 1)), x);
    end
    repeat (3) step(0, 0, 0, 16'd0);
    check("pending_writes", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
